// File: rtl/weight_stream_reader.sv
// Sweeps a layer's weight ROM address space a programmable number of passes
// and presents each registered NUM-wide weight word on a valid/ready stream.
module weight_stream_reader #(
  parameter int unsigned WIDTH  = 16,
  parameter int unsigned NUM    = 256,
  parameter int unsigned ADDR   = 10,
  parameter int unsigned DEPTH  = 576,
  parameter int unsigned PASS_W = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [PASS_W-1:0] num_passes,
  output logic [ADDR-1:0]   rom_addr,
  input  logic [WIDTH-1:0]  rom_data [NUM],
  output logic [WIDTH-1:0]  w_out    [NUM],
  output logic              w_valid,
  input  logic              w_ready,
  output logic              w_last,
  output logic              busy,
  output logic              done
);

  localparam logic [ADDR-1:0] LAST_ADDR = ADDR'(DEPTH - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    STREAM = 2'd1,
    FLUSH  = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic [ADDR-1:0]   addr_q, addr_d;
  logic [PASS_W-1:0] pass_q, pass_d;
  logic [PASS_W-1:0] npass_q, npass_d;
  logic              w_valid_q, w_valid_d;
  logic              w_last_q, w_last_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              load;
  logic [WIDTH-1:0]  w_out_q [NUM];

  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    pass_d    = pass_q;
    npass_d   = npass_q;
    w_valid_d = w_valid_q;
    w_last_d  = w_last_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    load      = 1'b0;

    case (state_q)
      IDLE: begin
        if (start) begin
          if (num_passes != '0) begin
            npass_d = num_passes;
            addr_d  = '0;
            pass_d  = '0;
            busy_d  = 1'b1;
            state_d = STREAM;
          end else begin
            done_d = 1'b1;
          end
        end
      end

      STREAM: begin
        if (!w_valid_q || w_ready) begin
          load      = 1'b1;
          w_valid_d = 1'b1;
          w_last_d  = (addr_q == LAST_ADDR);
          if (addr_q == LAST_ADDR) begin
            addr_d = '0;
            pass_d = pass_q + 1'b1;
            // The final word is already loaded; FLUSH only waits for its handshake.
            if (pass_q + 1'b1 == npass_q) begin
              state_d = FLUSH;
            end
          end else begin
            addr_d = addr_q + 1'b1;
          end
        end
      end

      FLUSH: begin
        if (w_valid_q && w_ready) begin
          w_valid_d = 1'b0;
          w_last_d  = 1'b0;
          done_d    = 1'b1;
          busy_d    = 1'b0;
          state_d   = IDLE;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      addr_q    <= '0;
      pass_q    <= '0;
      npass_q   <= '0;
      w_valid_q <= 1'b0;
      w_last_q  <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      pass_q    <= pass_d;
      npass_q   <= npass_d;
      w_valid_q <= w_valid_d;
      w_last_q  <= w_last_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < NUM; i++) begin
        w_out_q[i] <= '0;
      end
    end else if (load) begin
      w_out_q <= rom_data;
    end
  end

  assign rom_addr = addr_q;
  assign w_out    = w_out_q;
  assign w_valid  = w_valid_q;
  assign w_last   = w_last_q;
  assign busy     = busy_q;
  assign done     = done_q;

endmodule

// File: tb/tb_weight_stream_reader.sv
// Bench for weight_stream_reader: a hashed combinational ROM model, and a
// stream scoreboard that expects DEPTH*num_passes beats in ROM order.
module tb_weight_stream_reader;

  localparam int unsigned WIDTH  = 16;
  localparam int unsigned NUM    = 256;
  localparam int unsigned ADDR   = 10;
  localparam int unsigned DEPTH  = 576;
  localparam int unsigned PASS_W = 16;

  logic              clk;
  logic              rst_n;
  logic              start;
  logic [PASS_W-1:0] num_passes;
  logic [ADDR-1:0]   rom_addr;
  logic [WIDTH-1:0]  rom_data [NUM];
  logic [WIDTH-1:0]  w_out    [NUM];
  logic              w_valid;
  logic              w_ready;
  logic              w_last;
  logic              busy;
  logic              done;

  int unsigned total;
  int unsigned bad;

  weight_stream_reader #(
    .WIDTH (WIDTH),
    .NUM   (NUM),
    .ADDR  (ADDR),
    .DEPTH (DEPTH),
    .PASS_W(PASS_W)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .num_passes(num_passes),
    .rom_addr  (rom_addr),
    .rom_data  (rom_data),
    .w_out     (w_out),
    .w_valid   (w_valid),
    .w_ready   (w_ready),
    .w_last    (w_last),
    .busy      (busy),
    .done      (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Distinct per address for every lane, and sensitive to the high address bits.
  function automatic logic [WIDTH-1:0] rom_fn(input int unsigned a, input int unsigned i);
    int unsigned v;
    v = (a * 40503) + (i * 947) ^ (i << 7) ^ (a >> 3);
    return v[WIDTH-1:0];
  endfunction

  always_comb begin
    for (int i = 0; i < NUM; i++) begin
      rom_data[i] = rom_fn(int'(rom_addr), i);
    end
  end

  // Drives one run and scores every cycle of it. restart_at/reset_at of 0 disable
  // the mid-run start pulse and the mid-run reset respectively.
  task automatic run_stream(input int unsigned np, input bit rand_ready,
                            input int unsigned restart_at, input int unsigned reset_at);
    int unsigned n;
    int unsigned beat;
    int unsigned cyc;
    int unsigned limit;
    int unsigned exp_addr;
    int unsigned bad_el;
    int unsigned first_bad;
    bit pulsed;
    bit fin;
    bit expect_done;
    n = DEPTH * np;
    beat = 0;
    cyc = 0;
    limit = 4 * n + 50;
    pulsed = 0;
    fin = 0;
    expect_done = 0;

    @(posedge clk); #1;
    start = 1'b1;
    num_passes = PASS_W'(np);
    w_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
    @(posedge clk); #1;
    start = 1'b0;

    while (!fin) begin
      @(negedge clk);
      if (cyc <= 1) begin
        total++;
        if (w_valid !== (cyc == 1)) begin
          bad++;
          $display("FAIL first_valid cyc=%0d w_valid=%b expected=%b", cyc, w_valid, cyc == 1);
        end
      end
      exp_addr = (beat + int'(w_valid)) % DEPTH;
      total++;
      if (int'(rom_addr) !== exp_addr) begin
        bad++;
        $display("FAIL rom_addr beat=%0d got=%0d expected=%0d", beat, rom_addr, exp_addr);
      end
      if (expect_done) begin
        total++;
        if (done !== 1'b1 || busy !== 1'b0 || w_valid !== 1'b0) begin
          bad++;
          $display("FAIL done_pulse done=%b busy=%b w_valid=%b expected 1/0/0", done, busy, w_valid);
        end
        fin = 1;
      end else begin
        total++;
        if (done !== 1'b0 || busy !== 1'b1) begin
          bad++;
          $display("FAIL run_status beat=%0d done=%b busy=%b expected 0/1", beat, done, busy);
        end
      end

      if (!fin && w_valid === 1'b1) begin
        bad_el = 0;
        first_bad = 0;
        for (int i = 0; i < NUM; i++) begin
          if (w_out[i] !== rom_fn(beat % DEPTH, i)) begin
            if (bad_el == 0) first_bad = i;
            bad_el++;
          end
        end
        total++;
        if (bad_el != 0) begin
          bad++;
          $display("FAIL w_out beat=%0d lane=%0d got=%h expected=%h (%0d lanes wrong)", beat,
                   first_bad, w_out[first_bad], rom_fn(beat % DEPTH, first_bad), bad_el);
        end
        total++;
        if (w_last !== ((beat % DEPTH) == DEPTH - 1)) begin
          bad++;
          $display("FAIL w_last beat=%0d got=%b expected=%b", beat, w_last,
                   (beat % DEPTH) == DEPTH - 1);
        end
      end

      if (!fin && reset_at != 0 && beat == reset_at && w_valid === 1'b1) begin
        rst_n = 1'b0;
        #1;
        bad_el = 0;
        for (int i = 0; i < NUM; i++) begin
          if (w_out[i] !== '0) bad_el++;
        end
        total++;
        if (bad_el != 0 || rom_addr !== '0 || w_valid !== 1'b0 || w_last !== 1'b0 ||
            busy !== 1'b0 || done !== 1'b0) begin
          bad++;
          $display("FAIL midrun_reset addr=%0d valid=%b last=%b busy=%b done=%b nonzero_lanes=%0d expected all 0",
                   rom_addr, w_valid, w_last, busy, done, bad_el);
        end
        @(posedge clk); #1;
        rst_n = 1'b1;
        fin = 1;
      end

      if (!fin && w_valid === 1'b1 && w_ready === 1'b1) begin
        beat++;
        if (beat == n) expect_done = 1;
      end

      if (!fin && cyc > limit) begin
        bad++;
        total++;
        $display("FAIL timeout beats=%0d expected=%0d", beat, n);
        fin = 1;
      end
      cyc++;

      if (!fin) begin
        @(posedge clk); #1;
        start = 1'b0;
        w_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
        if (restart_at != 0 && beat >= restart_at && !pulsed) begin
          start = 1'b1;
          num_passes = PASS_W'(7);
          pulsed = 1;
        end
      end
    end
    start = 1'b0;
  endtask

  task automatic test_idle_after;
    @(negedge clk);
    total++;
    if (w_valid !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin
      bad++;
      $display("FAIL idle_after valid=%b busy=%b done=%b expected 0/0/0", w_valid, busy, done);
    end
  endtask

  task automatic test_reset;
    int unsigned nz;
    rst_n = 1'b0;
    start = 1'b0;
    num_passes = '0;
    w_ready = 1'b0;
    #1;
    nz = 0;
    for (int i = 0; i < NUM; i++) begin
      if (w_out[i] !== '0) nz++;
    end
    total++;
    if (nz != 0 || rom_addr !== '0 || w_valid !== 1'b0 || w_last !== 1'b0 ||
        busy !== 1'b0 || done !== 1'b0) begin
      bad++;
      $display("FAIL reset addr=%0d valid=%b last=%b busy=%b done=%b nonzero_lanes=%0d expected all 0",
               rom_addr, w_valid, w_last, busy, done, nz);
    end
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic test_single_pass;
    run_stream(1, 1'b0, 0, 0);
    test_idle_after();
  endtask

  task automatic test_multi_pass;
    run_stream(3, 1'b0, 0, 0);
    test_idle_after();
  endtask

  task automatic test_backpressure;
    run_stream(2, 1'b1, 0, 0);
    test_idle_after();
  endtask

  task automatic test_zero_passes;
    @(posedge clk); #1;
    start = 1'b1;
    num_passes = '0;
    w_ready = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    @(negedge clk);
    total++;
    if (done !== 1'b1 || busy !== 1'b0 || w_valid !== 1'b0) begin
      bad++;
      $display("FAIL zero_passes done=%b busy=%b w_valid=%b expected 1/0/0", done, busy, w_valid);
    end
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      total++;
      if (done !== 1'b0 || busy !== 1'b0 || w_valid !== 1'b0) begin
        bad++;
        $display("FAIL zero_passes_after k=%0d done=%b busy=%b w_valid=%b expected 0/0/0",
                 k, done, busy, w_valid);
      end
    end
  endtask

  task automatic test_restart_ignored;
    run_stream(1, 1'b0, 100, 0);
    test_idle_after();
  endtask

  task automatic test_reset_midrun;
    run_stream(2, 1'b0, 0, 300);
    run_stream(1, 1'b0, 0, 0);
    test_idle_after();
  endtask

  initial begin
    total = 0;
    bad = 0;
    test_reset();
    test_single_pass();
    test_multi_pass();
    test_backpressure();
    test_zero_passes();
    test_restart_ignored();
    test_reset_midrun();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/weight_stream_reader.md
Name: weight_stream_reader

Overview:
- Reads one layer's weight ROM address space in order, for example the fire6 expand3 combined ROM of 576 entries.
- Drives the ROM address and registers each NUM-wide weight word coming back.
- Presents the words to the conv/MAC array on a valid/ready stream.
- Repeats the full address sweep a programmable number of passes, then signals done.

Parameters:
- WIDTH, 16, bit width of one weight.
- NUM, 256, weights per ROM word (parallel filters).
- ADDR, 10, ROM address width.
- DEPTH, 576, number of valid ROM entries (addresses 0..DEPTH-1).
- PASS_W, 16, width of the pass-count input.

Ports:
- clk  input  1  clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  single-cycle request to begin a run; sampled only in IDLE.
- num_passes  input  PASS_W  number of full address sweeps; latched on accepted start.
- rom_addr  output  ADDR  address to the combinational weight ROM wrapper.
- rom_data  input  [WIDTH-1:0] x NUM (unpacked array)  ROM word for rom_addr, same cycle.
- w_out  output  [WIDTH-1:0] x NUM (unpacked array)  registered weight word.
- w_valid  output  1  w_out holds a valid word.
- w_ready  input  1  consumer accepts w_out this cycle.
- w_last  output  1  w_out is the entry at address DEPTH-1 of the current pass.
- busy  output  1  high from accepted start until done.
- done  output  1  single-cycle pulse at run completion.

Behaviour:
- Reset values: rom_addr=0, all w_out elements=0, w_valid=0, w_last=0, busy=0, done=0. The FSM goes to IDLE and the address and pass counters clear. Reset acts immediately, including mid-run. No stream state survives reset.
- FSM states are IDLE, STREAM, FLUSH.
- IDLE, start=1, num_passes>0:
  - Latch num_passes.
  - rom_addr=0, pass counter=0.
  - busy=1, go to STREAM.
- IDLE, start=1, num_passes=0: done pulses the next cycle, busy stays 0, no beat is issued.
- start outside IDLE is ignored.
- Load condition in STREAM: load = (!w_valid || w_ready).
- On load:
  - w_out <= rom_data, w_valid <= 1, w_last <= (rom_addr==DEPTH-1).
  - rom_addr advances.
- Address wrap:
  - rom_addr==DEPTH-1 → 0, and the pass counter increments.
  - If that entry was the last address of the final pass, go to FLUSH and hold rom_addr at 0.
- Throughput: one beat per cycle with w_ready held high. First w_valid appears 1 cycle after start is accepted.
- Backpressure: while w_valid=1 and w_ready=0, w_out, w_last and rom_addr are held stable.
- FLUSH:
  - On the w_valid && w_ready handshake: w_valid <= 0, w_last <= 0, done <= 1 for one cycle, busy <= 0, go to IDLE.
  - done is asserted the cycle after the final handshake.
- Total beats per run: DEPTH*num_passes. w_last is asserted on beats DEPTH, 2*DEPTH, and so on.
- The ROM is combinational; this block performs no address-range split. rom_addr never exceeds DEPTH-1.
- A w_ready high while w_valid=0 has no effect.

Test Plan:
- start with num_passes=1, w_ready=1:
  - Expect 576 consecutive beats, rom_addr 0..575.
  - w_out equals the ROM model word at each address, including correct data across the 511→512 crossing.
  - w_last only on beat 576; done 1 cycle after that handshake; busy low afterwards.
- num_passes=3, w_ready=1: 1728 beats; rom_addr wraps 575→0 twice; w_last on beats 576, 1152 and 1728; exactly one done pulse.
- Random w_ready (50% duty), num_passes=2:
  - w_out and w_last stable whenever valid&&!ready.
  - No beat dropped or duplicated; received sequence equals the ROM contents twice.
- start with num_passes=0: done pulses next cycle; w_valid and busy never assert.
- start pulsed again mid-run (beat 100): ignored; run still delivers exactly 576*num_passes beats.
- rst_n low mid-run (beat 300, w_valid=1):
  - All outputs return to reset values immediately.
  - After release, a new start with num_passes=1 streams from address 0 with 576 beats.
